pipe_unload: RTL and testbench



---
 rtl/pipe_unload_pkg.sv | 14 +
 rtl/pipe_unload_if.sv | 25 ++
 rtl/pipe_unload_cnt.sv | 36 +++
 rtl/pipe_unload.sv | 93 +++++++++
 tb/tb_pipe_unload.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_unload_pkg.sv
// Shared definitions for the word unloader: FSM encoding and beat-counter sizing.
package pipe_unload_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A single-word vector still needs a one-bit counter.
  function automatic int cnt_width(input int num);
    return (num < 1) ? 1 : $clog2(num + 1);
  endfunction

endpackage

// File: rtl/pipe_unload_if.sv
// Vector-in / word-out stream bundle; slave side is the unloader, master side feeds and drains it.
interface pipe_unload_if #(
  parameter int NUM   = 3,
  parameter int WIDTH = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [(NUM+1)*WIDTH-1:0]   in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pipe_unload_cnt.sv
// Beat counter for the unloader: clear has priority over increment; term_o flags the final word.
module pipe_unload_cnt
  import pipe_unload_pkg::*;
#(
  parameter int NUM = 3,
  parameter int CW  = cnt_width(NUM)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CW'(NUM));

endmodule

// File: rtl/pipe_unload.sv
// Parallel-to-serial unloader: takes NUM+1 packed words and streams them out oldest-first
// over a valid/ready handshake, with out_last on the top word.
module pipe_unload
  import pipe_unload_pkg::*;
#(
  parameter int NUM   = 3,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  pipe_unload_if.slave bus
);

  localparam int TW = (NUM + 1) * WIDTH;

  state_t          state_q, state_d;
  logic [TW-1:0]   shreg_q, shreg_d;
  logic            last;
  logic            out_valid;
  logic            in_ready;
  logic            beat;
  logic            load;
  logic            cnt_clr;
  logic            cnt_inc;

  pipe_unload_cnt #(
    .NUM (NUM)
  ) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_o (last)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush beats load, load beats the return to IDLE on the last beat.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = SEND;
    end else if (beat && last) begin
      state_d = IDLE;
    end
  end

  // Output logic; in_ready opens on the last beat so a new vector follows with no bubble.
  always_comb begin
    out_valid = (state_q == SEND);
    in_ready  = ((state_q == IDLE) || (out_valid && bus.out_ready && last)) && !flush;
  end

  assign beat    = out_valid && bus.out_ready;
  assign load    = bus.in_valid && in_ready;
  assign cnt_clr = flush || load || (beat && last);
  assign cnt_inc = beat && !last;

  always_comb begin
    shreg_d = shreg_q;
    if (flush) begin
      shreg_d = '0;
    end else if (load) begin
      shreg_d = bus.in_data;
    end else if (beat && !last) begin
      shreg_d = shreg_q >> WIDTH;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = shreg_q[WIDTH-1:0];
  assign bus.out_last  = out_valid && last;

endmodule

// File: tb/tb_pipe_unload.sv
// Directed bench for pipe_unload: a word-queue model checked every cycle plus literal sequence checks.
module tb_pipe_unload;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  pipe_unload_if #(.NUM(3), .WIDTH(8))  ifa();
  pipe_unload_if #(.NUM(0), .WIDTH(16)) ifb();

  pipe_unload #(.NUM(3), .WIDTH(8)) dut_a (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush_a),
    .bus   (ifa)
  );

  pipe_unload #(.NUM(0), .WIDTH(16)) dut_b (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush_b),
    .bus   (ifb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Model: the words still owed to the consumer, oldest first.
  logic [7:0] exp_q[$];
  logic [7:0] log_data[$];
  bit         log_last[$];
  bit         log_rdy[$];
  int         log_cyc[$];
  int         cyc = 0;
  int         load_cyc = 0;
  bit         m_rdy, m_beat, m_load;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      cyc++;
      m_rdy = ((exp_q.size() == 0) || (exp_q.size() == 1 && ifa.out_ready)) && !flush_a;
      chk("a_out_valid", 32'(ifa.out_valid), 32'(exp_q.size() > 0));
      chk("a_in_ready", 32'(ifa.in_ready), 32'(m_rdy));
      if (exp_q.size() > 0) begin
        chk("a_out_data", 32'(ifa.out_data), 32'(exp_q[0]));
        chk("a_out_last", 32'(ifa.out_last), 32'(exp_q.size() == 1));
      end
      m_beat = (exp_q.size() > 0) && ifa.out_ready;
      m_load = ifa.in_valid && m_rdy;
      if (flush_a) begin
        $display("flush cyc=%0d", cyc);
        exp_q.delete();
      end else begin
        if (m_beat) begin
          log_data.push_back(ifa.out_data);
          log_last.push_back(ifa.out_last);
          log_rdy.push_back(ifa.in_ready);
          log_cyc.push_back(cyc);
          $display("beat cyc=%0d data=%h last=%b", cyc, ifa.out_data, ifa.out_last);
          void'(exp_q.pop_front());
        end
        if (m_load) begin
          load_cyc = cyc;
          $display("load cyc=%0d vec=%h", cyc, ifa.in_data);
          for (int k = 0; k < 4; k++) exp_q.push_back(ifa.in_data[k*8 +: 8]);
        end
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    ifa.in_valid  = iv;
    ifa.in_data   = d;
    ifa.out_ready = ordy;
    flush_a       = fl;
  endtask

  task automatic clr_log();
    log_data.delete();
    log_last.delete();
    log_rdy.delete();
    log_cyc.delete();
  endtask

  task automatic chk_words(input string nm, input logic [63:0] w, input int n, input bit consec);
    chk({nm, "_count"}, 32'(log_data.size()), 32'(n));
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      chk(nm, 32'(log_data[i]), 32'(w[i*8 +: 8]));
      if (consec) chk({nm, "_cycle"}, 32'(log_cyc[i]), 32'(log_cyc[0] + i));
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_out_data", 32'(ifa.out_data), 0);
    chk("rst_out_last", 32'(ifa.out_last), 0);
    #10 rstn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ifa.in_ready), 1);
    chk("rst_b_in_ready", 32'(ifb.in_ready), 1);

    // Streaming with out_ready held high.
    clr_log();
    step(1, 32'h44332211, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_words("t1_order", 64'h44332211, 4, 1'b1);
    if (log_data.size() == 4) begin
      chk("t1_latency", 32'(log_cyc[0]), 32'(load_cyc + 1));
      chk("t1_last0", 32'(log_last[0]), 0);
      chk("t1_last3", 32'(log_last[3]), 1);
      chk("t1_rdy0", 32'(log_rdy[0]), 0);
      chk("t1_rdy3", 32'(log_rdy[3]), 1);
    end

    // Backpressure 1,0,0,1,1,0,1 with upstream pushing junk mid-vector.
    begin
      bit [6:0] pr = 7'b1011001;
      bit [6:0] iv = 7'b0000110;
      clr_log();
      step(1, 32'h44332211, 0, 0);
      for (int i = 0; i < 7; i++) step(iv[i], 32'hEEEEEEEE, pr[i], 0);
      step(0, 0, 0, 0);
      chk_words("t2_order", 64'h44332211, 4, 1'b0);
    end

    // Back-to-back vectors, second presented on the last beat.
    clr_log();
    step(1, 32'h44332211, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    step(1, 32'hDDCCBBAA, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_words("t3_order", 64'hDDCCBBAA44332211, 8, 1'b1);

    // Flush after the second word, then a fresh vector.
    clr_log();
    step(1, 32'h44332211, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    #1;
    chk("t4_flush_valid", 32'(ifa.out_valid), 0);
    chk("t4_flush_data", 32'(ifa.out_data), 0);
    chk("t4_flush_last", 32'(ifa.out_last), 0);
    chk("t4_flush_rdy", 32'(ifa.in_ready), 1);
    step(1, 32'h08070605, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_words("t4_order", 64'h0000080706052211, 6, 1'b0);

    // Asynchronous reset between edges mid-vector.
    step(1, 32'h44332211, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(ifa.out_valid), 0);
    chk("t5_rst_data", 32'(ifa.out_data), 0);
    chk("t5_rst_last", 32'(ifa.out_last), 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    chk("t5_rel_rdy", 32'(ifa.in_ready), 1);
    chk("t5_rel_valid", 32'(ifa.out_valid), 0);

    // Single-word configuration, back-to-back loads.
    @(posedge clk); #1;
    ifb.in_valid = 1'b1; ifb.in_data = 16'h1234; ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    $display("b word data=%h last=%b", ifb.out_data, ifb.out_last);
    chk("t6_valid1", 32'(ifb.out_valid), 1);
    chk("t6_data1", 32'(ifb.out_data), 32'h1234);
    chk("t6_last1", 32'(ifb.out_last), 1);
    chk("t6_rdy1", 32'(ifb.in_ready), 1);
    ifb.in_data = 16'hABCD;
    @(posedge clk); #1;
    $display("b word data=%h last=%b", ifb.out_data, ifb.out_last);
    chk("t6_valid2", 32'(ifb.out_valid), 1);
    chk("t6_data2", 32'(ifb.out_data), 32'hABCD);
    chk("t6_last2", 32'(ifb.out_last), 1);
    ifb.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle_valid", 32'(ifb.out_valid), 0);
    chk("t6_idle_rdy", 32'(ifb.in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
